uart_rx_sink: RTL

Synthesizable UART receiver that terminates the MCU's `TXD` line. It oversamples the serial line, decodes 8N1 frames (8O1/8E1 when parity is compiled in) and buffers received bytes in a small FIFO with a valid/ready pop interface. It sits beside `mcu_top` in the simulation top, driven by `TXD`, and can also be reused in FPGA builds as a loopback or capture target.

---
 rtl/uart_sink_pkg.sv | 24 ++
 rtl/uart_sink_fifo.sv | 60 ++++++
 rtl/uart_rx_sink.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_sink_pkg.sv
// Shared types and helpers for the uart_rx_sink receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_sink_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_e;

    // Parity bit a well-formed frame carries: even parity makes the total
    // count of ones even, odd parity inverts that.
    function automatic logic uart_parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                             input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sink_fifo.sv
// First-word-fall-through FIFO for received bytes.
// Pointers carry one extra MSB so full and empty are told apart without a
// separate counter; occupancy is the pointer difference.
module uart_sink_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    // A pop on an empty FIFO is ignored; a push while full is accepted only
    // when a pop frees the head slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // Head byte is presented combinationally; forced to zero when empty so the
    // output has a defined value out of reset.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    // NOTE: the array is deliberately not reset; empty gates rdata, so stale
    // contents are never observed and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_sink.sv
// UART receiver terminating the MCU TXD line: 2-flop synchronizer,
// oversampling bit timer, frame FSM and a FWFT byte FIFO.
// Optional feature macro: UART_RX_PARITY_EN (8O1/8E1 frames, parity_err live);
// without it frames are 8N1 and parity_err is tied low.
module uart_rx_sink
    import uart_sink_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          RXD,
    output logic [UART_DATA_BITS-1:0]     rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

    rx_state_e                 state;
    rx_state_e                 state_next;
    logic                      sync_q;
    logic                      rxs;
    logic                      rxs_d;
    logic [TW-1:0]             timer;
    logic [BW-1:0]             bit_cnt;
    logic [UART_DATA_BITS-1:0] shift_reg;

    logic                      timer_clr;
    logic                      frame_clr;
    logic                      shift_en;
    logic                      push;
    logic                      frame_err_set;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      ovr_event;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic                      par_chk;
    logic                      par_bad;
    logic                      parity_err_set;
`endif

    // Synchronize RXD and keep the previous synchronized value for edge detect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= 1'b1;
            rxs    <= 1'b1;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= RXD;
            rxs    <= sync_q;
            rxs_d  <= rxs;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state and per-cycle control strobes.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        timer_clr     = 1'b0;
        frame_clr     = 1'b0;
        shift_en      = 1'b0;
        push          = 1'b0;
        frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk        = 1'b0;
        parity_err_set = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (rxs_d && !rxs) begin
                    state_next = ST_START;
                    frame_clr  = 1'b1;
                end
            end
            ST_START: begin
                // Mid-bit sample of the start bit; a high line means a glitch.
                if (timer == HALF_M1) begin
                    timer_clr  = 1'b1;
                    state_next = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer == FULL_M1) begin
                    timer_clr = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (timer == FULL_M1) begin
                    timer_clr  = 1'b1;
                    par_chk    = 1'b1;
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (timer == FULL_M1) begin
                    timer_clr  = 1'b1;
                    state_next = ST_IDLE;
                    // A framing error outranks a parity error on the same frame.
                    if (!rxs) begin
                        frame_err_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        parity_err_set = 1'b1;
`endif
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Bit timer: free-runs inside a bit, restarted at every sample point.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            timer <= '0;
        else if (timer_clr) timer <= '0;
        else                timer <= timer + 1'b1;
    end

    // Data shift register (LSB first) and bit counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (frame_clr) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_reg <= {rxs, shift_reg[UART_DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity verdict for the current frame, cleared at each start edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            par_bad <= 1'b0;
        else if (frame_clr) par_bad <= 1'b0;
        else if (par_chk)   par_bad <= (rxs != uart_parity_bit(shift_reg, PAR_ODD));
    end

    // One-cycle parity error pulse, the cycle after the stop sample.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) parity_err <= 1'b0;
        else     parity_err <= parity_err_set;
    end
`else
    assign parity_err = 1'b0;
`endif

    // One-cycle framing error pulse, the cycle after the stop sample.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) frame_err <= 1'b0;
        else     frame_err <= frame_err_set;
    end

    // A good byte is lost only when the FIFO is full and no pop frees a slot.
    assign ovr_event = push && fifo_full && !(rx_ready && !fifo_empty);

    // Sticky overrun flag; a new event wins over a simultaneous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) overrun <= 1'b0;
        else     overrun <= ovr_event || (overrun && !ovr_clr);
    end

    uart_sink_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .wdata (shift_reg),
        .pop   (rx_ready),
        .rdata (rx_data),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid = !fifo_empty;

endmodule
